// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU instruction port, CPU data port, shared memory port and
// sticky error flags seen by mem_port_arbiter.
//   slave  : the arbiter's view (takes requests, drives mem_* and resp)
//   master : the surrounding CPU/memory view
interface mem_port_arbiter_if;
  // instruction fetch port
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  // data port
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_mbe;
  logic        data_resp;
  logic [31:0] data_rdata;
  // shared memory port
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mbe;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  // sticky error flags
  logic        err_timeout;
  logic        err_proto;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write, data_addr, data_wdata, data_mbe,
    input  mem_resp, mem_rdata,
    output inst_resp, inst_rdata, data_resp, data_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
    output err_timeout, err_proto
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write, data_addr, data_wdata, data_mbe,
    output mem_resp, mem_rdata,
    input  inst_resp, inst_rdata, data_resp, data_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
    input  err_timeout, err_proto
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises the CPU instruction and data ports onto one
// shared word-wide memory port. One transaction in flight at a time; the
// winning request is registered onto mem_*, the completion is routed back
// combinationally to the owner in the mem_resp cycle, and a watchdog forces
// completion if mem_resp never arrives.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants when both
// ports pend; otherwise the data port always wins ties.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
  } mem_req_t;

  state_t      state;
  mem_req_t    mreq;
  logic        last_data;      // last grant went to the data port
  logic [CW-1:0] wd_cnt;
  logic        err_timeout_q;
  logic        err_proto_q;

  logic        inst_pend;
  logic        data_pend;
  logic        pick_data;
  logic        busy;
  logic        owner_req;
  logic        expire;
  logic        done_ok;
  logic        resp_pulse;
  logic [31:0] resp_rdata;

  // Request decode, arbitration choice, and completion/expiry detection.
  always_comb begin
    inst_pend = bus.inst_read;
    data_pend = bus.data_read | bus.data_write;
`ifdef ARB_ROUND_ROBIN_EN
    // on a tie, hand the port to whoever did not have it last
    pick_data = data_pend & (~inst_pend | ~last_data);
`else
    pick_data = data_pend;
`endif
    busy       = (state != IDLE);
    owner_req  = (state == DATA) ? data_pend : inst_pend;
    // a real mem_resp in the expiry cycle takes precedence over the watchdog
    expire     = busy & ~bus.mem_resp & (wd_cnt == WD_LAST);
    // an owner that abandoned its request gets no completion pulse
    done_ok    = busy & bus.mem_resp & owner_req;
    resp_pulse = done_ok | expire;
    resp_rdata = done_ok ? bus.mem_rdata : 32'h0;
  end

`ifndef ARB_ROUND_ROBIN_EN
  // last grant is still tracked but does not steer fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_data;
`endif

  // Route completion to the owner; the non-owner sees zeros.
  always_comb begin
    bus.inst_resp  = resp_pulse & (state == INST);
    bus.inst_rdata = (state == INST) ? resp_rdata : 32'h0;
    bus.data_resp  = resp_pulse & (state == DATA);
    bus.data_rdata = (state == DATA) ? resp_rdata : 32'h0;
  end

  assign bus.mem_read    = mreq.read;
  assign bus.mem_write   = mreq.write;
  assign bus.mem_addr    = mreq.addr;
  assign bus.mem_wdata   = mreq.wdata;
  assign bus.mem_mbe     = mreq.mbe;
  // expiry is flagged in the same cycle as the forced completion
  assign bus.err_timeout = err_timeout_q | expire;
  assign bus.err_proto   = err_proto_q;

  // Arbitration FSM with registered shared-port request, watchdog and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mreq          <= '0;
      last_data     <= 1'b0;
      wd_cnt        <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // nothing is outstanding, so a completion here is spurious
          if (bus.mem_resp) err_proto_q <= 1'b1;
          if (inst_pend | data_pend) begin
            wd_cnt <= '0;
            if (pick_data) begin
              state       <= DATA;
              last_data   <= 1'b1;
              mreq.addr   <= bus.data_addr;
              mreq.wdata  <= bus.data_wdata;
              mreq.mbe    <= bus.data_mbe;
              // read+write together is resolved as a store
              mreq.write  <= bus.data_write;
              mreq.read   <= ~bus.data_write;
              if (bus.data_read & bus.data_write) err_proto_q <= 1'b1;
            end else begin
              state       <= INST;
              last_data   <= 1'b0;
              mreq.addr   <= bus.inst_addr;
              mreq.wdata  <= 32'h0;
              mreq.mbe    <= 4'hF;
              mreq.write  <= 1'b0;
              mreq.read   <= 1'b1;
            end
          end
        end
        INST, DATA: begin
          if (bus.mem_resp) begin
            if (!owner_req) err_proto_q <= 1'b1;
            mreq.read  <= 1'b0;
            mreq.write <= 1'b0;
            state      <= IDLE;
          end else if (expire) begin
            err_timeout_q <= 1'b1;
            mreq.read     <= 1'b0;
            mreq.write    <= 1'b0;
            state         <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT_CYCLES=8). A queue-based requester
// model predicts grant order from the arbitration rules, and each issued
// transaction is checked against the request that should have won.
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    int          lat;
    logic [31:0] rdata;
  } req_t;

  int    vectors = 0;
  int    miscompares = 0;
  bit    model_last_data = 1'b0;
  req_t  iq[$];
  req_t  dq[$];
  string order_s;
  string exp_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_read  = 1'b0;
    bus.inst_addr  = 32'h0;
    bus.data_read  = 1'b0;
    bus.data_write = 1'b0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.data_mbe   = 4'h0;
    bus.mem_resp   = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_last_data = 1'b0;
    tick();
  endtask

  function automatic req_t mk(input int kind, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mbe,
                              input int lat, input logic [31:0] rdata);
    req_t r;
    r.kind = kind; r.addr = addr; r.wdata = wdata;
    r.mbe = mbe; r.lat = lat; r.rdata = rdata;
    return r;
  endfunction

  function automatic req_t rand_req(input int kind);
    return mk(kind, $urandom() & 32'hFFFF_FFFC, $urandom(),
              4'($urandom_range(1, 15)), int'($urandom_range(1, 5)), $urandom());
  endfunction

  // shared-port contents expected while request r is in flight
  task automatic check_issue(input string tag, input req_t r);
    chk({tag, "_read"},  bus.mem_read,  r.kind != 2);
    chk({tag, "_write"}, bus.mem_write, r.kind == 2);
    chk({tag, "_addr"},  bus.mem_addr,  r.addr);
    chk({tag, "_mbe"},   bus.mem_mbe,   (r.kind == 0) ? 4'hF : r.mbe);
    if (r.kind == 0)      chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    else if (r.kind == 2) chk({tag, "_wdata"}, bus.mem_wdata, r.wdata);
  endtask

  // Present queue heads, predict the winner, serve it, repeat until empty.
  task automatic run_mixed();
    bit   ip, dp, win_d;
    req_t r;
    order_s = "";
    while (iq.size() > 0 || dq.size() > 0) begin
      ip = iq.size() > 0;
      dp = dq.size() > 0;
      idle_inputs();
      if (ip) begin
        bus.inst_read = 1'b1;
        bus.inst_addr = iq[0].addr;
      end
      if (dp) begin
        bus.data_read  = (dq[0].kind == 1);
        bus.data_write = (dq[0].kind == 2);
        bus.data_addr  = dq[0].addr;
        bus.data_wdata = dq[0].wdata;
        bus.data_mbe   = dq[0].mbe;
      end
      if (ip && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = !model_last_data;
`else
        win_d = 1'b1;
`endif
      end else begin
        win_d = dp;
      end
      r = win_d ? dq[0] : iq[0];
      model_last_data = win_d;
      if (win_d) order_s = {order_s, "D"};
      else       order_s = {order_s, "I"};

      tick();
      check_issue("issue", r);
      for (int k = 1; k < r.lat; k++) begin
        tick();
        check_issue("hold", r);
        chk("wait_inst_resp", bus.inst_resp, 32'h0);
        chk("wait_data_resp", bus.data_resp, 32'h0);
      end
      tick();
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = r.rdata;
      #1;
      if (win_d) begin
        chk("data_resp",       bus.data_resp,  32'h1);
        chk("data_rdata",      bus.data_rdata, r.rdata);
        chk("inst_resp_other", bus.inst_resp,  32'h0);
        chk("inst_rdata_other", bus.inst_rdata, 32'h0);
        void'(dq.pop_front());
      end else begin
        chk("inst_resp",       bus.inst_resp,  32'h1);
        chk("inst_rdata",      bus.inst_rdata, r.rdata);
        chk("data_resp_other", bus.data_resp,  32'h0);
        chk("data_rdata_other", bus.data_rdata, 32'h0);
        void'(iq.pop_front());
      end
      tick();
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = 32'h0;
      chk("dead_read",  bus.mem_read,  32'h0);
      chk("dead_write", bus.mem_write, 32'h0);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read",  bus.mem_read,  32'h0);
    chk("rst_mem_write", bus.mem_write, 32'h0);
    chk("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_mbe",   bus.mem_mbe,   32'h0);
    chk("rst_err_to",    bus.err_timeout, 32'h0);
    chk("rst_err_proto", bus.err_proto, 32'h0);
    rst = 1'b1;
    tick();

    // single fetch, response 3 cycles after issue
    iq.push_back(mk(0, 32'h60, 32'h0, 4'h0, 3, 32'h00A00093));
    run_mixed();

    // masked store
    dq.push_back(mk(2, 32'h100, 32'hDEADBEEF, 4'b1100, 4, 32'h0));
    run_mixed();

    // two of each pending together from reset
    do_reset();
    iq.push_back(rand_req(0));
    iq.push_back(rand_req(0));
    dq.push_back(rand_req(1));
    dq.push_back(rand_req(2));
    run_mixed();
`ifdef ARB_ROUND_ROBIN_EN
    exp_o = "DIDI";
`else
    exp_o = "DDII";
`endif
    chk("order_len", order_s.len(), exp_o.len());
    for (int k = 0; k < 4; k++)
      chk("grant_order", (order_s.len() > k) ? order_s[k] : 8'h0, exp_o[k]);

    // randomized mixes of fetches, loads and stores
    for (int rnd = 0; rnd < 6; rnd++) begin
      int ni, nd;
      ni = int'($urandom_range(0, 4));
      nd = int'($urandom_range(0, 4));
      for (int k = 0; k < ni; k++) iq.push_back(rand_req(0));
      for (int k = 0; k < nd; k++) dq.push_back(rand_req(int'($urandom_range(1, 2))));
      run_mixed();
    end

    // watchdog: no mem_resp ever
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h40;
    tick();
    model_last_data = 1'b0;
    chk("wd_issue_read", bus.mem_read, 32'h1);
    repeat (TO - 2) tick();
    chk("wd_pre_resp",   bus.inst_resp,   32'h0);
    chk("wd_pre_err",    bus.err_timeout, 32'h0);
    tick();
    chk("wd_inst_resp",  bus.inst_resp,   32'h1);
    chk("wd_inst_rdata", bus.inst_rdata,  32'h0);
    chk("wd_err",        bus.err_timeout, 32'h1);
    chk("wd_data_resp",  bus.data_resp,   32'h0);
    tick();
    bus.inst_read = 1'b0;
    chk("wd_post_read",  bus.mem_read,    32'h0);
    chk("wd_post_resp",  bus.inst_resp,   32'h0);
    chk("wd_sticky",     bus.err_timeout, 32'h1);

    // asynchronous reset two cycles into a store
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h200;
    bus.data_wdata = 32'h1234_5678;
    bus.data_mbe   = 4'hF;
    tick();
    chk("ar_issue_write", bus.mem_write, 32'h1);
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("ar_pre_resp", bus.data_resp, 32'h1);
    rst = 1'b0;
    #1;
    chk("ar_mem_write", bus.mem_write,   32'h0);
    chk("ar_mem_addr",  bus.mem_addr,    32'h0);
    chk("ar_data_resp", bus.data_resp,   32'h0);
    chk("ar_err_to",    bus.err_timeout, 32'h0);
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_last_data = 1'b0;
    tick();
    iq.push_back(rand_req(0));
    run_mixed();

    // requester drops its load before completion
    chk("pv_err_before", bus.err_proto, 32'h0);
    bus.data_read = 1'b1;
    bus.data_addr = 32'h300;
    bus.data_mbe  = 4'hF;
    tick();
    model_last_data = 1'b1;
    chk("pv_issue_read", bus.mem_read, 32'h1);
    tick();
    bus.data_read = 1'b0;
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    #1;
    chk("pv_data_resp",  bus.data_resp,  32'h0);
    chk("pv_data_rdata", bus.data_rdata, 32'h0);
    tick();
    bus.mem_resp = 1'b0;
    chk("pv_err",        bus.err_proto, 32'h1);
    chk("pv_mem_read",   bus.mem_read,  32'h0);
    iq.push_back(rand_req(0));
    run_mixed();

    // mem_resp with nothing outstanding
    do_reset();
    chk("ir_err_before", bus.err_proto, 32'h0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("ir_inst_resp", bus.inst_resp, 32'h0);
    chk("ir_data_resp", bus.data_resp, 32'h0);
    tick();
    bus.mem_resp = 1'b0;
    chk("ir_err", bus.err_proto, 32'h1);

    // read and write together resolve as a store
    do_reset();
    bus.data_read  = 1'b1;
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h400;
    bus.data_wdata = 32'h0BAD_F00D;
    bus.data_mbe   = 4'b0011;
    tick();
    model_last_data = 1'b1;
    chk("rw_write", bus.mem_write, 32'h1);
    chk("rw_read",  bus.mem_read,  32'h0);
    chk("rw_mbe",   bus.mem_mbe,   32'h3);
    chk("rw_wdata", bus.mem_wdata, 32'h0BAD_F00D);
    chk("rw_err",   bus.err_proto, 32'h1);
    bus.mem_resp = 1'b1;
    #1;
    chk("rw_resp",  bus.data_resp, 32'h1);
    tick();
    idle_inputs();
    chk("rw_done",  bus.mem_write, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the CPU's two memory ports onto one shared word-wide memory port. The CPU instruction fetch port (inst_*) and data port (data_*) each issue at most one outstanding request and hold it until their resp pulse. The block serialises these requests, registers the winning request, and drives the shared port (mem_*). It routes mem_resp and mem_rdata back to the winning requester. It sits directly downstream of the cpu top, between cpu and the memory model or cache hierarchy.

## Interface
- TIMEOUT_CYCLES, 1024: cycles allowed for mem_resp after issue; sets counter width $clog2(TIMEOUT_CYCLES+1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-low.
- inst_read  in  1  instruction fetch request.
- inst_addr  in  32  fetch address (word aligned).
- inst_resp  out  1  one-cycle fetch completion.
- inst_rdata  out  32  fetch data, valid while inst_resp.
- data_read  in  1  load request.
- data_write  in  1  store request.
- data_addr  in  32  data address (word aligned).
- data_wdata  in  32  store data.
- data_mbe  in  4  store byte enables.
- data_resp  out  1  one-cycle data completion.
- data_rdata  out  32  load data, valid while data_resp.
- mem_read  out  1  shared port read.
- mem_write  out  1  shared port write.
- mem_addr  out  32  shared port address.
- mem_wdata  out  32  shared port write data.
- mem_mbe  out  4  shared port byte enables.
- mem_resp  in  1  shared port completion, one cycle.
- mem_rdata  in  32  shared port read data, valid while mem_resp.
- err_timeout  out  1  sticky; set on watchdog expiry.
- err_proto  out  1  sticky; set on protocol violation.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - INST: instruction transaction in flight.
  - DATA: data transaction in flight.
- Reset state and values:
  - FSM in IDLE; last_grant=INST; watchdog counter=0.
  - All registered mem_* outputs are 0.
  - err_timeout=0; err_proto=0.
- IDLE:
  - Pending requests are inst_read and (data_read|data_write).
  - Data only pending: grant data.
  - Inst only pending: grant inst.
  - Both pending: grant per arbitration policy (see Configuration).
- Grant action:
  - Capture the request into mem_* registers.
    - Inst: mem_read=1, mem_write=0, mem_mbe=4'hF, mem_wdata=0.
    - Data load: mem_read=1, mem_mbe=data_mbe.
    - Data store: mem_write=1, mem_mbe=data_mbe.
  - Clear the watchdog counter.
  - Enter INST or DATA; update last_grant.
- INST/DATA:
  - mem_* hold their registered values; later requester input changes are ignored.
  - On mem_resp:
    - Pulse the owner's resp combinationally in the same cycle.
    - Drive the owner's rdata = mem_rdata.
    - Clear mem_read and mem_write.
    - Return to IDLE.
  - If the owner's request has dropped by the mem_resp cycle, suppress the resp pulse and set err_proto.
- Non-owner outputs:
  - The non-owner's resp is always 0.
  - Its rdata is 32'h0.
- data_read & data_write both 1 at grant: treat as a store and set err_proto.
- Watchdog:
  - Increments each busy cycle without mem_resp.
  - On reaching TIMEOUT_CYCLES:
    - Set err_timeout.
    - Pulse the owner's resp with rdata=0.
    - Clear mem_read and mem_write.
    - Return to IDLE.
  - A mem_resp in the same cycle as expiry wins: normal completion, no error.
- mem_resp in IDLE is ignored and sets err_proto.

## Timing
- Grant latency: request first seen in IDLE at cycle N gives mem_read/mem_write high at cycle N+1.
- Response latency: mem_resp at cycle M gives owner resp at cycle M (zero latency).
- Back-to-back: the next grant is evaluated in IDLE at M+1, with mem_* asserted at M+2. There is one dead cycle between transactions.
- Minimum per-access latency is 2 cycles, assuming mem_resp can arrive one cycle after issue.
- Asynchronous reset mid-transaction:
  - mem_* clear immediately; resp outputs go 0.
  - The in-flight memory operation is abandoned.
  - Error flags clear.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both requests pend in IDLE, grant the port opposite last_grant.
- ARB_ROUND_ROBIN_EN undefined: data always wins ties (fixed priority). last_grant is still maintained but unused.

## Test plan
- Single fetch:
  - Stimulus: inst_read=1, inst_addr=32'h60; mem_resp returns 3 cycles after issue with mem_rdata=32'h00A00093.
  - Required: mem_read=1 and mem_addr=32'h60 one cycle after the request; inst_resp=1 and inst_rdata=32'h00A00093 in the mem_resp cycle; data_resp=0 throughout.
- Store with mask:
  - Stimulus: data_write=1, data_addr=32'h100, data_wdata=32'hDEADBEEF, data_mbe=4'b1100.
  - Required: mem_write=1, mem_mbe=4'b1100 and mem_wdata=32'hDEADBEEF held until mem_resp; data_resp pulses once.
- Simultaneous requests, 2 transactions each:
  - Without ARB_ROUND_ROBIN_EN: grant order is D,D,I,I.
  - With ARB_ROUND_ROBIN_EN (starting from reset last_grant=INST): grant order is D,I,D,I.
- Watchdog with TIMEOUT_CYCLES=8:
  - Stimulus: mem_resp never arrives.
  - Required: on the 8th busy cycle, inst_resp=1 with rdata=0 and err_timeout=1; mem_read=0 on the next cycle.
- Reset mid-transaction:
  - Stimulus: drop rst to 0 two cycles into a DATA transaction.
  - Required: mem_write=0 and data_resp=0 immediately, without waiting for a clock edge. After release, an inst_read is granted normally.
- Protocol violation:
  - Stimulus: drop data_read before mem_resp.
  - Required: data_resp is suppressed and err_proto=1; the FSM returns to IDLE.
